// File: rtl/snes_pkg.sv
// Shared SNES controller constants and reader FSM state encoding.
// The game logic imports the same button indices to decode p1data/p2data.
package snes_pkg;

   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   localparam int NUM_BTN      = 12;
   localparam int NUM_SER_BITS = 16;

endpackage

// File: rtl/snes_half_tick.sv
// Half-bit-period timebase: 1-cycle tick on the last cycle of every HALF_BIT_CYC window,
// phase-aligned to the cycle after restart.
module snes_half_tick #(
   parameter int HALF_BIT_CYC = 288
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1;
   localparam logic [CW-1:0] LOAD = CW'(HALF_BIT_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= LOAD;
      else if (restart || cnt == '0)
         cnt <= LOAD;
      else
         cnt <= cnt - 1'b1;
   end

   assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/snes_ctrl_reader.sv
// Polls one SNES controller (latch, 16 clocked bits) and publishes a validated,
// active-high 12-bit button word atomically once per frame.
module snes_ctrl_reader
   import snes_pkg::*;
#(
   parameter int HALF_BIT_CYC = 288,
   parameter int POLL_CYC     = 800000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ser_data,
   output logic               ctrl_latch,
   output logic               ctrl_clk,
   output logic [NUM_BTN-1:0] data,
   output logic               valid,
   output logic               frame_err
);

   if (HALF_BIT_CYC < 2 || POLL_CYC < 34 * HALF_BIT_CYC + 4) begin : g_bad_params
      $error("snes_ctrl_reader: need HALF_BIT_CYC >= 2 and POLL_CYC >= 34*HALF_BIT_CYC+4");
   end

   localparam int PW = $clog2(POLL_CYC);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(NUM_SER_BITS - 1);

   state_t                  state, nxt;
   logic                    first_pend;
   logic [PW-1:0]           poll_cnt;
   logic [3:0]              bit_idx;
   logic                    phase;     // 0: first half (clock high), 1: second half
   logic [NUM_SER_BITS-1:0] sr;
   logic [1:0]              sync;
   logic                    start;
   logic                    tick;

   snes_half_tick #(.HALF_BIT_CYC(HALF_BIT_CYC)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (start),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt        = state;
      start      = 1'b0;
      ctrl_latch = 1'b0;
      ctrl_clk   = 1'b1;
      case (state)
         IDLE: begin
            if (first_pend || poll_cnt == POLL_LAST) begin
               nxt   = LATCH;
               start = 1'b1;
            end
         end
         LATCH: begin
            ctrl_latch = 1'b1;
            if (tick && phase) nxt = SHIFT;
         end
         SHIFT: begin
            ctrl_clk = !phase;
            if (tick && phase && bit_idx == LAST_BIT) nxt = DONE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync       <= 2'b11;
         first_pend <= 1'b1;
         poll_cnt   <= '0;
         bit_idx    <= '0;
         phase      <= 1'b0;
         sr         <= '1;
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync      <= {sync[0], ser_data};
         valid     <= 1'b0;
         frame_err <= 1'b0;
         // Realigned to 0 at each frame start so latch rises are exactly POLL_CYC apart.
         poll_cnt  <= (start || poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
         if (start) begin
            first_pend <= 1'b0;
            phase      <= 1'b0;
            bit_idx    <= '0;
         end else if (tick && (state == LATCH || state == SHIFT)) begin
            phase <= ~phase;
            if (state == SHIFT && !phase) sr <= {sync[1], sr[NUM_SER_BITS-1:1]};
            if (state == SHIFT && phase)  bit_idx <= bit_idx + 1'b1;
         end
         // Trailer bits 12..15 always read 1 on a genuine pad; anything else is a bad frame.
         if (state == DONE) begin
            if (&sr[NUM_SER_BITS-1:NUM_BTN]) begin
               data  <= ~sr[NUM_BTN-1:0];
               valid <= 1'b1;
            end else begin
               frame_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_snes_ctrl_reader.sv
// Self-checking bench: behavioural SNES pad model, vector table, random frames, reset abort.
module tb_snes_ctrl_reader;

   localparam int H = 4;
   localparam int P = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ser_data;
   logic        ctrl_latch, ctrl_clk, valid, frame_err;
   logic [11:0] data;

   always #5 clk = ~clk;

   snes_ctrl_reader #(.HALF_BIT_CYC(H), .POLL_CYC(P)) dut (
      .clk        (clk),
      .reset      (reset),
      .ser_data   (ser_data),
      .ctrl_latch (ctrl_latch),
      .ctrl_clk   (ctrl_clk),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err)
   );

   // Pad model: parallel load while latched, shift on clock rise, bit 0 on DATA.
   logic [15:0] word = 16'hFFFF;
   logic [15:0] q    = 16'hFFFF;
   logic        stuck_en = 1'b0, stuck_val = 1'b1;

   always @(posedge ctrl_clk or posedge ctrl_latch) begin
      if (ctrl_latch) q <= word;
      else            q <= {1'b1, q[15:1]};
   end
   assign ser_data = stuck_en ? stuck_val : q[0];

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor of pin-level timing, sampled on the falling edge.
   logic latch_q = 1'b0, clk_q = 1'b1;
   int last_rise = -1, last_gap = -1, latch_len = 0, lowrun = 0;
   int good_p = 0, bad_p = 0, n_valid = 0, n_err = 0, last_valid_cyc = -1;
   int both = 0, clk_bad = 0;

   always @(negedge clk) begin
      if (!reset) begin
         latch_q   = 1'b0;
         clk_q     = 1'b1;
         last_rise = -1;
         lowrun    = 0;
      end else begin
         if (ctrl_latch && !latch_q) begin
            if (last_rise >= 0) last_gap = cyc - last_rise;
            last_rise = cyc;
            good_p = 0; bad_p = 0; latch_len = 0;
         end
         if (ctrl_latch) latch_len++;
         if (!ctrl_clk) lowrun++;
         else if (!clk_q) begin
            if (lowrun == H) good_p++; else bad_p++;
            lowrun = 0;
         end
         if (valid) begin n_valid++; last_valid_cyc = cyc; end
         if (frame_err) n_err++;
         if (valid && frame_err) both++;
         if (ctrl_latch && !ctrl_clk) clk_bad++;
         latch_q = ctrl_latch;
         clk_q   = ctrl_clk;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_result(output logic gv, output logic ge);
      bit done = 0;
      gv = 1'b0; ge = 1'b0;
      for (int n = 0; n < 600 && !done; n++) begin
         @(negedge clk); #1;
         if (valid || frame_err) begin
            gv = valid; ge = frame_err; done = 1;
         end
      end
      if (!done) chk("result_timeout", 32'd1, 32'd0);
   endtask

   // Reference: button pressed when its serial bit is 0; frame good when all 4 trailer bits are 1.
   function automatic void ref_frame(input logic [15:0] w, input logic [11:0] prev,
                                     output logic v, output logic [11:0] d);
      v = ($countones(w[15:12]) == 4);
      d = prev;
      if (v) for (int b = 0; b < 12; b++) d[b] = (w[b] == 1'b0);
   endfunction

   typedef struct {
      logic [15:0] w;
      logic        exp_v;
      logic [11:0] exp_d;
   } vec_t;

   vec_t tbl[6];

   task automatic run_frame(input string nm, input logic [15:0] w, input logic exp_v,
                            input logic [11:0] exp_d);
      logic gv, ge;
      int   ev0;
      word = w;
      ev0  = n_valid + n_err;
      wait_result(gv, ge);
      chk({nm, "_valid"}, 32'(gv), 32'(exp_v));
      chk({nm, "_err"}, 32'(ge), 32'(!exp_v));
      chk({nm, "_data"}, 32'(data), 32'(exp_d));
      chk({nm, "_gap"}, last_gap, P);
      chk({nm, "_clkpulses"}, good_p * 100 + bad_p, 16 * 100);
      chk({nm, "_one_event"}, n_valid + n_err - ev0, 1);
   endtask

   initial begin
      logic        gv, ge, rv;
      logic [11:0] model_d, rd;
      logic [15:0] w;
      int          rel, nv0;

      tbl[0] = '{16'hF5A5, 1'b1, 12'hA5A};
      tbl[1] = '{16'h0FFF, 1'b0, 12'hA5A};
      tbl[2] = '{16'hFFFF, 1'b1, 12'h000};
      tbl[3] = '{16'hF000, 1'b1, 12'hFFF};
      tbl[4] = '{16'h7FFF, 1'b0, 12'hFFF};
      tbl[5] = '{16'hFA5A, 1'b1, 12'h5A5};

      // Reset state
      word = 16'hFFFE;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_latch", 32'(ctrl_latch), 0);
      chk("rst_clk", 32'(ctrl_clk), 1);
      chk("rst_data", 32'(data), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_err", 32'(frame_err), 0);

      // First frame, B pressed
      @(negedge clk); #2;
      reset = 1'b1;
      rel = cyc;
      wait_result(gv, ge);
      chk("t1_valid", 32'(gv), 1);
      chk("t1_err", 32'(ge), 0);
      chk("t1_data", 32'(data), 32'h001);
      chk("t1_latch_start", last_rise - rel, 1);
      chk("t1_latch_len", latch_len, 2 * H);
      chk("t1_latency", last_valid_cyc - last_rise, 34 * H + 1);
      chk("t1_clkpulses", good_p * 100 + bad_p, 16 * 100);

      foreach (tbl[i]) run_frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].exp_v, tbl[i].exp_d);

      model_d = tbl[5].exp_d;
      for (int i = 0; i < 12; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 1) == 1) w[15:12] = 4'hF;
         ref_frame(w, model_d, rv, rd);
         run_frame($sformatf("rnd%0d", i), w, rv, rd);
         model_d = rd;
      end

      // Absent pad: DATA pulled high
      stuck_en = 1'b1; stuck_val = 1'b1;
      for (int i = 0; i < 3; i++) run_frame($sformatf("stuck1_%0d", i), 16'hFFFF, 1'b1, 12'h000);
      // DATA shorted low
      stuck_val = 1'b0;
      for (int i = 0; i < 2; i++) run_frame($sformatf("stuck0_%0d", i), 16'h0000, 1'b0, 12'h000);
      stuck_en = 1'b0;

      // Reset during SHIFT bit 7 of a frame following a good one
      run_frame("pre_rst", 16'hFFFE, 1'b1, 12'h001);
      word = 16'hF000;
      for (int n = 0; n < 400 && !ctrl_latch; n++) @(negedge clk);
      chk("mid_latch_seen", 32'(ctrl_latch), 1);
      repeat (2 * H + 7 * 2 * H + 2) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_latch", 32'(ctrl_latch), 0);
      chk("mid_rst_clk", 32'(ctrl_clk), 1);
      chk("mid_rst_data", 32'(data), 0);
      chk("mid_rst_valid", 32'(valid), 0);
      chk("mid_rst_err", 32'(frame_err), 0);
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      rel = cyc;
      nv0 = n_valid + n_err;
      wait_result(gv, ge);
      chk("post_rst_valid", 32'(gv), 1);
      chk("post_rst_data", 32'(data), 32'hFFF);
      chk("post_rst_start", last_rise - rel, 1);
      chk("post_rst_latency", last_valid_cyc - last_rise, 34 * H + 1);
      chk("post_rst_events", n_valid + n_err - nv0, 1);

      chk("clk_high_in_latch", clk_bad, 0);
      chk("valid_err_exclusive", both, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
